// File: rtl/branch_cond_seq_pkg.sv
// Shared control definitions: condition codes, FSM encodings and a decode helper
// for the branch-condition sequencer.
package branch_cond_seq_pkg;

   localparam logic [2:0] COND_BEQ = 3'd0;
   localparam logic [2:0] COND_BNE = 3'd1;
   localparam logic [2:0] COND_BLE = 3'd2;
   localparam logic [2:0] COND_BGT = 3'd3;
   localparam logic [2:0] COND_BLT = 3'd4;
   localparam logic [2:0] COND_OVF = 3'd5;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_EVAL_ENC = 2'd1;
   localparam logic [1:0] ST_DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_EVAL = ST_EVAL_ENC,
      ST_DONE = ST_DONE_ENC
   } state_t;

   function automatic logic cond_illegal(input logic [2:0] c);
      return (c > COND_OVF);
   endfunction

endpackage

// File: rtl/branch_cond_seq.sv
// Branch-condition sequencer: captures ALU flags and mux select on start, waits EVAL_WAIT
// extra cycles for the datapath mux to settle, then pulses done / pc_wr_cond / err.
module branch_cond_seq
   import branch_cond_seq_pkg::*;
#(
   parameter int unsigned EVAL_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] cond,
   input  logic       alu_eq,
   input  logic       alu_lt,
   input  logic       alu_gt,
   input  logic       alu_of,
   output logic       flag0,
   output logic       flag1,
   output logic       flag2,
   output logic       flag3,
   output logic       flag4,
   output logic       flag5,
   output logic [2:0] sel,
   input  logic       taken_in,
   output logic       busy,
   output logic       done,
   output logic       pc_wr_cond,
   output logic       err
);

   localparam logic [3:0] LP_WAIT = 4'(EVAL_WAIT);

   state_t     r_state;
   logic [5:0] r_flags;
   logic [2:0] r_sel;
   logic [3:0] r_cnt;
   logic       r_taken;
   logic       r_illegal;
   logic       w_in_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_flags   <= 6'd0;
         r_sel     <= 3'd0;
         r_cnt     <= 4'd0;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  // Bit order matches the downstream mux inputs, indexed by cond.
                  r_flags   <= {alu_of, alu_lt, alu_gt, alu_lt | alu_eq, ~alu_eq, alu_eq};
                  r_sel     <= cond;
                  r_illegal <= cond_illegal(cond);
                  r_cnt     <= LP_WAIT;
                  r_state   <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (r_cnt == 4'd0) begin
                  r_taken <= taken_in;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_in_done  = (r_state == ST_DONE);
   assign busy       = (r_state != ST_IDLE);
   assign done       = w_in_done;
   assign pc_wr_cond = w_in_done & r_taken & ~r_illegal;
   assign err        = w_in_done & r_illegal;

   assign flag0 = r_flags[0];
   assign flag1 = r_flags[1];
   assign flag2 = r_flags[2];
   assign flag3 = r_flags[3];
   assign flag4 = r_flags[4];
   assign flag5 = r_flags[5];
   assign sel   = r_sel;

endmodule

// File: tb/tb_branch_cond_seq.sv
// Scoreboard bench: two instances (EVAL_WAIT 0 and 3), random + directed stimulus,
// expected results from the branch rules queued at issue and checked when done fires.
module tb_branch_cond_seq;
   import branch_cond_seq_pkg::*;

   localparam int unsigned W0 = 0;
   localparam int unsigned W1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   [2];
   logic       start [2];
   logic [2:0] cond  [2];
   logic       eq    [2];
   logic       lt    [2];
   logic       gt    [2];
   logic       of    [2];
   logic       taken [2];
   logic       busy  [2];
   logic       done  [2];
   logic       pcw   [2];
   logic       err   [2];
   logic [2:0] sel   [2];
   logic [5:0] fl    [2];

   branch_cond_seq #(.EVAL_WAIT(W0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .start(start[0]), .cond(cond[0]),
      .alu_eq(eq[0]), .alu_lt(lt[0]), .alu_gt(gt[0]), .alu_of(of[0]),
      .flag0(fl[0][0]), .flag1(fl[0][1]), .flag2(fl[0][2]),
      .flag3(fl[0][3]), .flag4(fl[0][4]), .flag5(fl[0][5]),
      .sel(sel[0]), .taken_in(taken[0]), .busy(busy[0]), .done(done[0]),
      .pc_wr_cond(pcw[0]), .err(err[0])
   );

   branch_cond_seq #(.EVAL_WAIT(W1)) u_dut1 (
      .clk(clk), .reset(rst[1]), .start(start[1]), .cond(cond[1]),
      .alu_eq(eq[1]), .alu_lt(lt[1]), .alu_gt(gt[1]), .alu_of(of[1]),
      .flag0(fl[1][0]), .flag1(fl[1][1]), .flag2(fl[1][2]),
      .flag3(fl[1][3]), .flag4(fl[1][4]), .flag5(fl[1][5]),
      .sel(sel[1]), .taken_in(taken[1]), .busy(busy[1]), .done(done[1]),
      .pc_wr_cond(pcw[1]), .err(err[1])
   );

   // Datapath 6:1 mux model; the illegal selects 6 and 7 return 1.
   assign taken[0] = |(({2'b11, fl[0]} >> sel[0]) & 8'd1);
   assign taken[1] = |(({2'b11, fl[1]} >> sel[1]) & 8'd1);

   typedef struct packed {
      logic [5:0] flags;
      logic [2:0] sel;
      logic       pc;
      logic       er;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   busy_left [2];
   int   last_done [2];
   bit   chk_period = 1'b0;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   // Branch rules at the level of the ISA: flags per condition, taken decision,
   // and done seen at the sampling point 1+W edges after the accepting edge.
   function automatic exp_t model(input bit [2:0] c, input bit e, input bit l,
                                  input bit g, input bit o, input int at, input int w);
      exp_t r;
      bit   t;
      r.flags = {o, l, g, l | e, ~e, e};
      r.sel   = c;
      case (c)
         3'd0: t = e;
         3'd1: t = ~e;
         3'd2: t = l | e;
         3'd3: t = g;
         3'd4: t = l;
         3'd5: t = o;
         default: t = 1'b0;
      endcase
      r.er  = (c > 3'd5);
      r.pc  = t & ~r.er;
      r.cyc = at + 1 + w;
      return r;
   endfunction

   task automatic step(input int i, input bit st, input bit [2:0] c, input bit e,
                       input bit l, input bit g, input bit o, input bit rs);
      int w;
      start[i] = st; cond[i] = c; eq[i] = e; lt[i] = l; gt[i] = g; of[i] = o; rst[i] = rs;
      @(posedge clk);
      #1;
      w = (i == 0) ? int'(W0) : int'(W1);
      if (rs) begin
         busy_left[i] = 0;
         if (i == 0) q0.delete(); else q1.delete();
      end else if (busy_left[i] == 0 && st) begin
         if (i == 0) q0.push_back(model(c, e, l, g, o, cyc, w));
         else        q1.push_back(model(c, e, l, g, o, cyc, w));
         busy_left[i] = 2 + w;
      end else if (busy_left[i] > 0) begin
         busy_left[i]--;
      end
      chk("busy", 32'(busy[i]), 32'(busy_left[i] != 0));
      if (rs) begin
         chk("rst_flags", 32'(fl[i]), 0);
         chk("rst_sel", 32'(sel[i]), 0);
         chk("rst_done", 32'(done[i]), 0);
         chk("rst_pcw", 32'(pcw[i]), 0);
         chk("rst_err", 32'(err[i]), 0);
      end
   endtask

   task automatic idle(input int i, input int n);
      for (int k = 0; k < n; k++) step(i, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic rnd(input int i, input int n, input bit always_start);
      for (int k = 0; k < n; k++)
         step(i, always_start | ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (done[i] === 1'b1) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_done dut%0d at cycle %0d: done=1, required 0", i, cyc);
            end else begin
               if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
               chk("flags", 32'(fl[i]), 32'(e.flags));
               chk("sel", 32'(sel[i]), 32'(e.sel));
               chk("pc_wr_cond", 32'(pcw[i]), 32'(e.pc));
               chk("err", 32'(err[i]), 32'(e.er));
            end
            if (chk_period && i == 1 && last_done[1] > 0)
               chk("done_period", 32'(cyc - last_done[1]), 32'(3 + W1));
            last_done[i] = cyc;
         end else begin
            chk("pcw_outside_done", 32'(pcw[i]), 0);
            chk("err_outside_done", 32'(err[i]), 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; cond[i] = 3'd0;
         eq[i] = 1'b0; lt[i] = 1'b0; gt[i] = 1'b0; of[i] = 1'b0;
         busy_left[i] = 0; last_done[i] = 0;
      end

      // Reset state, then reset winning over a simultaneous start.
      step(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(0, 3);

      // beq taken, bgt not taken with lt set, illegal cond with mux returning 1.
      step(0, 1'b1, COND_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(0, 3);
      step(0, 1'b1, COND_BGT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(0, 3);
      step(0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(0, 3);
      rnd(0, 150, 1'b0);
      idle(0, 4);

      // Reset in the first EVAL cycle aborts; no done may follow.
      step(0, 1'b1, COND_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(0, 10);

      step(1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1, 1'b1, COND_OVF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1, 6);

      // Start held high: one evaluation per 3+EVAL_WAIT cycles, busy gaps checked per cycle.
      last_done[1] = 0;
      chk_period = 1'b1;
      rnd(1, 36, 1'b1);
      idle(1, 7);
      chk_period = 1'b0;
      rnd(1, 150, 1'b0);
      idle(1, 8);

      chk("q0_drained", 32'(q0.size()), 0);
      chk("q1_drained", 32'(q1.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
